ldpc_enc_ctrl: RTL
==================

// Module: ldpc_enc_ctrl
// PURPOSE
//  Frame sequencer for the 360-bit-parallel LDPC parity encoder (encoder6 datapath + G ROM).
//  Clears the encoder, feeds K info bits with the bit index, then reads the P parity bits
//  out MSB-first. Emits one serial codeword stream: K systematic bits, then P parity bits.
//  Sits between the bit source (valid/ready) and the mapper/interleaver (no backpressure).
// PARAMETERS
//  K_BITS      4320  info bits per frame (N_GROUPS*GROUP)
//  GROUP       360   bits per ROM group / parity width P
//  CNT_W       13    width of enc_counter
//  ADDR_W      9     width of enc_out_addr
//  CLR_CYCLES  4     cycles enc_rst_n is held low before a frame (>= ROM latency + 1)
//  FLUSH_CYC   1     idle cycles between last info bit and first parity read
// PORTS
//  clk             in   1       system clock
//  rst_n           in   1       synchronous, active-low reset
//  start           in   1       pulse: begin a frame; ignored unless state==IDLE
//  s_valid         in   1       info bit available
//  s_data          in   1       info bit
//  s_ready         out  1       controller accepts bit this cycle (LOAD only)
//  m_valid         out  1       codeword bit valid
//  m_data          out  1       codeword bit
//  m_sof           out  1       with first systematic bit
//  m_eof           out  1       with last parity bit
//  busy            out  1       state != IDLE
//  frame_done      out  1       1-cycle pulse after m_eof
//  enc_rst_n       out  1       encoder clear (active-low, synchronous)
//  enc_din_valid   out  1       = s_valid & s_ready (combinational)
//  enc_din         out  1       = s_data (combinational)
//  enc_counter     out  CNT_W   index of current info bit, 0..K_BITS-1
//  enc_out_addr    out  ADDR_W  parity bit address
//  enc_dvc         out  1       encoder data_valid_check
//  enc_dout        in   1       encoder parity output, valid 1 cycle after enc_dvc
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except enc_rst_n=1; enc_counter=0; enc_out_addr=0.
//  FSM IDLE->CLR on start. CLR: enc_rst_n=0, enc_counter=0 for CLR_CYCLES, ->LOAD.
//  LOAD: s_ready=1; each accepted bit increments enc_counter; gaps in s_valid stall the
//   counter (enc_counter holds, enc_din_valid=0). Accept at index K_BITS-1 -> FLUSH,
//   s_ready drops the next cycle; enc_counter returns to 0 on that transition.
//  FLUSH: FLUSH_CYC cycles, nothing driven -> PARITY.
//  PARITY: GROUP cycles, enc_dvc=1, enc_out_addr=GROUP-1 down to 0 (registered) -> DRAIN.
//  DRAIN: 1 cycle for last enc_dout -> IDLE, frame_done=1 same cycle as IDLE entry.
//  Output path (all registered, latency 1): systematic: m_valid/m_data = accept/s_data of
//   previous cycle; parity: m_valid = enc_dvc delayed 1, m_data = enc_dout.
//  m_sof with the bit accepted at index 0; m_eof with parity read at addr 0.
//  start while busy: ignored, no effect on current frame. Codeword = K_BITS+GROUP m_valid beats.
//  rst_n low mid-frame: immediate IDLE, partial frame discarded, no m_eof/frame_done;
//   next frame's CLR re-clears encoder state.
//  enc_counter never exceeds K_BITS-1; enc_out_addr never wraps below 0.
// STRUCTURE
//  Package ldpc_pkg: K_BITS, GROUP, CNT_W, ADDR_W, state encoding (IDLE,CLR,LOAD,FLUSH,
//   PARITY,DRAIN). No sub-module needed; encoder instantiated by parent (ldpc_enc_top).
// TESTING
//  1 start, s_valid=1 solid, all-zero data -> 4680 m_valid beats, all m_data=0, 1 sof, 1 eof.
//  2 single 1 at info index 0 -> parity = ROM row 0 word, read bit 359 first; frame_done once.
//  3 random 4320 bits, s_valid 50% random gaps -> parity matches golden model; counter stalls.
//  4 two back-to-back frames, start at frame_done -> 2nd parity independent of 1st (clear OK).
//  5 rst_n low at enc_counter=2000 then new frame -> clean IDLE, 2nd frame matches golden.
//  6 start pulsed during PARITY -> ignored; frame length and m_eof timing unchanged.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared constants and state encoding for the LDPC encoder frame sequencer.
package ldpc_pkg;

    localparam int K_BITS     = 4320;
    localparam int GROUP      = 360;
    localparam int CNT_W      = 13;
    localparam int ADDR_W     = 9;
    localparam int CLR_CYCLES = 4;
    localparam int FLUSH_CYC  = 1;
    localparam int TMR_W      = 3;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(K_BITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(GROUP - 1);
    localparam logic [TMR_W-1:0]  TMR_CLR    = TMR_W'(CLR_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_FLUSH  = TMR_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_PARITY = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

endpackage

// File: rtl/ldpc_enc_ctrl.sv
// Frame sequencer: clears the parity encoder, streams K info bits into it, then
// reads the parity word out MSB-first and emits the serial codeword.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_CLR    | encoder held in clear for CLR_CYCLES cycles
// ST_LOAD   | accepting info bits, enc_counter tracks the bit index
// ST_FLUSH  | FLUSH_CYC idle cycles before the first parity read
// ST_PARITY | GROUP parity reads, enc_out_addr counting down to 0
// ST_DRAIN  | last parity bit returns from the encoder
module ldpc_enc_ctrl
    import ldpc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic              s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic              m_data,
    output logic              m_sof,
    output logic              m_eof,
    output logic              busy,
    output logic              frame_done,
    output logic              enc_rst_n,
    output logic              enc_din_valid,
    output logic              enc_din,
    output logic [CNT_W-1:0]  enc_counter,
    output logic [ADDR_W-1:0] enc_out_addr,
    output logic              enc_dvc,
    input  logic              enc_dout
);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               done_q, done_d;
    logic               sys_v_q, sys_data_q, par_v_q, sof_q, eof_q;
    logic               accept;

    assign s_ready       = (state_q == ST_LOAD);
    assign accept        = s_valid & s_ready;
    assign enc_din_valid = accept;
    assign enc_din       = s_data;
    assign enc_rst_n     = (state_q != ST_CLR);
    assign enc_dvc       = (state_q == ST_PARITY);
    assign busy          = (state_q != ST_IDLE);
    assign enc_counter   = cnt_q;
    assign enc_out_addr  = addr_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLR;
                    tmr_d   = TMR_CLR;
                    cnt_d   = '0;
                end
            end
            ST_CLR: begin
                cnt_d = '0;
                if (tmr_q == '0) begin
                    state_d = ST_LOAD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FLUSH;
                        tmr_d   = TMR_FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (tmr_q == '0) begin
                    state_d = ST_PARITY;
                    addr_d  = ADDR_FIRST;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_PARITY: begin
                // Address parks at 0 once the last read is issued.
                if (addr_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            done_q     <= 1'b0;
            sys_v_q    <= 1'b0;
            sys_data_q <= 1'b0;
            par_v_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            sys_v_q    <= accept;
            sys_data_q <= s_data;
            par_v_q    <= enc_dvc;
            sof_q      <= accept & (cnt_q == '0);
            eof_q      <= enc_dvc & (addr_q == '0);
        end
    end

    // The encoder presents each parity bit one cycle after its read, which is
    // exactly when par_v_q is high, so enc_dout is forwarded in that beat.
    assign m_valid    = sys_v_q | par_v_q;
    assign m_data     = par_v_q ? enc_dout : (sys_v_q & sys_data_q);
    assign m_sof      = sof_q;
    assign m_eof      = eof_q;
    assign frame_done = done_q;

endmodule
